// File: rtl/nios_seven_seg_pkg.sv
// Shared constants for the seven-segment controller: register map, CTRL bit
// positions, the CTRL register layout and the hex-to-segment table.
package nios_seven_seg_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_DIGITS   = 4'd1;
  localparam logic [3:0] ADDR_MASK     = 4'd2;
  localparam logic [3:0] ADDR_STATUS   = 4'd3;
  localparam logic [3:0] ADDR_RAW_BASE = 4'd8;

  localparam int CTRL_MODE_BIT  = 0;
  localparam int CTRL_BLINK_BIT = 1;
  localparam int CTRL_BLANK_BIT = 2;

  typedef struct packed {
    logic blank;
    logic blink_en;
    logic mode;
  } ctrl_t;

  // Logical segment pattern (1 = lit), bit0 = a .. bit6 = g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/nios_seven_seg_if.sv
// Avalon-MM slave bus for the seven-segment controller (0 wait states,
// readdata combinational).
interface nios_seven_seg_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_seven_seg_hex_decoder.sv
// Combinational nibble to logical seven-segment pattern (1 = lit).
module nios_seven_seg_hex_decoder
  import nios_seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex_to_seg(nibble);
endmodule

// File: rtl/nios_seven_seg_ctrl.sv
// Multi-digit seven-segment controller on an Avalon-MM slave: raw or hex
// digits, per-digit blink, global blank; out_port registered one stage after config.
module nios_seven_seg_ctrl
  import nios_seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios_seven_seg_if.slave         bus,
  output logic [7*NUM_DIGITS-1:0] out_port
);

  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
  localparam logic [7*NUM_DIGITS-1:0] OUT_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

  ctrl_t                   ctrl;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   mask;
  logic [6:0]              raw [NUM_DIGITS];
  logic [CNT_W-1:0]        cnt;
  logic                    phase;

  logic       wr_en;
  logic       ctrl_wr;
  logic [2:0] raw_idx;
  logic       raw_sel;
  logic       unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign ctrl_wr      = wr_en && (bus.address == ADDR_CTRL);
  assign raw_idx      = bus.address[2:0];
  assign raw_sel      = ({bus.address[3], 3'b000} == ADDR_RAW_BASE) &&
                        (int'(raw_idx) < NUM_DIGITS);
  assign unused_wdata = ^{1'b0, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= '0;
      digits <= '0;
      mask   <= '0;
      for (int d = 0; d < NUM_DIGITS; d++) raw[d] <= '0;
    end else begin
      if (ctrl_wr)
        ctrl <= ctrl_t'(bus.writedata[2:0]);
      if (wr_en && (bus.address == ADDR_DIGITS))
        digits <= bus.writedata[4*NUM_DIGITS-1:0];
      if (wr_en && (bus.address == ADDR_MASK))
        mask <= bus.writedata[NUM_DIGITS-1:0];
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (wr_en && raw_sel && (raw_idx == 3'(d)))
          raw[d] <= bus.writedata[6:0];
      end
    end
  end

  // A CTRL write that leaves or enters blink mode restarts the timer; it
  // overrides a wrap happening in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (ctrl_wr && (!bus.writedata[CTRL_BLINK_BIT] || !ctrl.blink_en)) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!ctrl.blink_en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  logic [6:0] hex_seg [NUM_DIGITS];

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dec
    nios_seven_seg_hex_decoder u_dec (
      .nibble (digits[4*d +: 4]),
      .seg    (hex_seg[d])
    );
  end

  logic [7*NUM_DIGITS-1:0] seg_lit;

  always_comb begin
    seg_lit = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (!(ctrl.blank || (ctrl.blink_en && phase && mask[d])))
        seg_lit[7*d +: 7] = ctrl.mode ? hex_seg[d] : raw[d];
    end
  end

  // Polarity is applied only here; everything upstream is logical.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      out_port <= OUT_OFF;
    else
      out_port <= (ACTIVE_LOW != 0) ? ~seg_lit : seg_lit;
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_CTRL:   rdata[2:0] = ctrl;
      ADDR_DIGITS: rdata[4*NUM_DIGITS-1:0] = digits;
      ADDR_MASK:   rdata[NUM_DIGITS-1:0] = mask;
      ADDR_STATUS: rdata[0] = phase;
      default: begin
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (raw_sel && (raw_idx == 3'(d)))
            rdata[6:0] = raw[d];
        end
      end
    endcase
  end

  assign bus.readdata = rdata;

endmodule

// File: tb/tb_nios_seven_seg_ctrl.sv
// Directed bench for nios_seven_seg_ctrl (6 digits, BLINK_DIV=4, active-low)
// with an out_port scoreboard queue.
module tb_nios_seven_seg_ctrl;

  localparam logic [41:0] ALL_OFF = 42'h3FF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [41:0] out_port;

  nios_seven_seg_if bus ();

  nios_seven_seg_ctrl #(
    .NUM_DIGITS (6),
    .BLINK_DIV  (4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [41:0] exp_q[$];
  logic [41:0] cur_exp;
  logic [41:0] lit;
  logic [41:0] off0;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic logic [41:0] hex_pins(input logic [23:0] dig);
    logic [41:0] v;
    for (int d = 0; d < 6; d++) v[7*d +: 7] = ~hex7(dig[4*d +: 4]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pop_chk(input string tag);
    logic [41:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    chk(tag, out_port, e);
    cur_exp = e;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(tag, bus.readdata, exp);
  endtask

  // Write, confirm out_port holds for the write edge, then changes one edge later.
  task automatic wr_out(input string tag, input logic [3:0] a, input logic [31:0] d,
                        input logic [41:0] exp_new);
    wr(a, d);
    chk({tag, "_lat"}, out_port, cur_exp);
    exp_q.push_back(exp_new);
    @(negedge clk);
    pop_chk(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    cur_exp        = ALL_OFF;
    repeat (2) @(negedge clk);

    chk("rst_out", out_port, ALL_OFF);
    rd_chk("rst_ctrl", 4'd0, 32'h0);
    rd_chk("rst_digits", 4'd1, 32'h0);
    rd_chk("rst_status", 4'd3, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Hex mode
    wr_out("hex_ctrl", 4'd0, 32'h1, hex_pins(24'h000000));
    wr_out("hex_digits", 4'd1, 32'h0000_FA51, hex_pins(24'h00FA51));
    chk("hex_const", out_port, {7'h40, 7'h40, 7'h0E, 7'h08, 7'h12, 7'h79});
    rd_chk("hex_rd", 4'd1, 32'h0000_FA51);

    // Raw mode and ignored addresses
    wr_out("raw_ctrl", 4'd0, 32'h0, ALL_OFF);
    wr_out("raw2", 4'd10, 32'h49, ~(42'h49 << 14));
    rd_chk("raw2_rd", 4'd10, 32'h49);
    wr_out("raw14", 4'd14, 32'h7F, ~(42'h49 << 14));
    rd_chk("raw14_rd", 4'd14, 32'h0);
    wr_out("unused5", 4'd5, 32'hFFFF_FFFF, ~(42'h49 << 14));
    rd_chk("unused5_rd", 4'd5, 32'h0);
    wr_out("status_wr", 4'd3, 32'h1, ~(42'h49 << 14));
    rd_chk("status_wr_rd", 4'd3, 32'h0);
    wr_out("mask_ff", 4'd2, 32'hFF, ~(42'h49 << 14));
    rd_chk("mask_ff_rd", 4'd2, 32'h3F);
    wr_out("mask_01", 4'd2, 32'h01, ~(42'h49 << 14));

    // Blink: digit0 masked, 4-cycle half period; clear lands on a wrap edge
    lit  = hex_pins(24'h00FA51);
    off0 = lit | 42'h7F;
    wr(4'd0, 32'h3);
    for (int k = 0; k < 20; k++) begin
      rd_chk("blink_phase", 4'd3, 32'((k / 4) % 2));
      if (k > 0) begin
        exp_q.push_back((((k - 1) / 4) % 2) != 0 ? off0 : lit);
        pop_chk("blink_out");
      end
      if (k < 19) @(negedge clk);
    end
    wr(4'd0, 32'h1);
    rd_chk("blink_clr_phase", 4'd3, 32'h0);
    chk("blink_clr_out0", out_port, lit);
    @(negedge clk);
    chk("blink_clr_out1", out_port, lit);
    cur_exp = lit;

    // Blank has priority over the digit source
    wr_out("blank_on", 4'd0, 32'h5, ALL_OFF);
    wr_out("blank_digits", 4'd1, 32'hFF88_8888, ALL_OFF);
    rd_chk("digits_trunc", 4'd1, 32'h0088_8888);
    wr_out("blank_off", 4'd0, 32'h1, 42'h0);

    // Reset asserted while phase=1
    wr(4'd0, 32'h3);
    repeat (5) @(negedge clk);
    rd_chk("mr_phase", 4'd3, 32'h1);
    chk("mr_pre", out_port, 42'h7F);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_async", out_port, ALL_OFF);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rd_chk("mr_ctrl", 4'd0, 32'h0);
    rd_chk("mr_digits", 4'd1, 32'h0);
    rd_chk("mr_mask", 4'd2, 32'h0);
    rd_chk("mr_raw2", 4'd10, 32'h0);
    chk("mr_out", out_port, ALL_OFF);
    repeat (5) @(negedge clk);
    rd_chk("mr_noblink", 4'd3, 32'h0);
    chk("mr_out_hold", out_port, ALL_OFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
